instruction_fetch: RTL

RV32 instruction fetch stage, directly upstream of the instruction decoder. It holds the program counter and issues one word request at a time to instruction memory. It captures the returned word with its PC and presents it to decode through a valid/ready handshake. Redirects (branches and jumps) from execute reload the PC and squash any in-flight or held instruction.

---
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// RV32 instruction fetch stage sitting directly in front of the decoder.
// Holds the program counter, issues one word request at a time to
// instruction memory, captures the returned word together with its PC and
// hands it to decode over a valid/ready handshake. Redirects from execute
// (taken branches and jumps) reload the PC and squash whatever instruction
// is in flight or being held.
//
// Parameters
//   RESET_PC    PC loaded on reset (bits [1:0] must be zero)
//   NOP_INSTR   word shown on instr while nothing is held (addi x0,x0,0)
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   imem_req        out  one-cycle request pulse to instruction memory
//   imem_addr       out  word-aligned fetch address (always the current pc)
//   imem_rvalid     in   memory response strobe, at least one cycle after req
//   imem_rdata      in   instruction word, valid with imem_rvalid
//   redirect_valid  in   load a new PC from execute
//   redirect_pc     in   redirect target; bits [1:0] are forced to zero
//   instr_valid     out  instr/instr_pc hold an instruction for decode
//   instr           out  instruction word for the decoder
//   instr_pc        out  address of instr
//   instr_ready     in   decode accepts the held instruction this cycle
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  // REQ   : request is on the bus this cycle
  // WAIT  : one live request outstanding, waiting for its response
  // HOLD  : instruction captured and presented to decode
  // FLUSH : one squashed request outstanding; its response must be swallowed
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n;
  logic [31:0] instr_pc_n;
  logic        instr_valid_n;
  logic [31:0] redirect_target;

  // Targets are always word aligned; the low bits from execute are dropped.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // The request is a pure decode of the state so that it is exactly one
  // cycle long per visit to REQ and is suppressed while reset is held.
  assign imem_req  = (state == REQ) & ~reset;
  assign imem_addr = pc;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0000_0000;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
    end
  end

  // Next-state and next-datapath logic. Every register holds by default.
  // A response arriving in REQ or HOLD would be a memory protocol error;
  // those states simply never look at imem_rvalid.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;

    case (state)
      REQ: begin
        if (redirect_valid) begin
          // The request already on the bus fetches the wrong address; it
          // still gets a response, which FLUSH will throw away.
          pc_n    = redirect_target;
          state_n = FLUSH;
        end else begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
          // If the response is here now it is simply dropped and the
          // target can be requested straight away; otherwise it is still
          // in flight and must be drained first.
          state_n = imem_rvalid ? REQ : FLUSH;
        end else if (imem_rvalid) begin
          instr_n       = imem_rdata;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          state_n       = HOLD;
        end
      end

      FLUSH: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
        end
        if (imem_rvalid) begin
          state_n = REQ;
        end
      end

      HOLD: begin
        // A redirect squashes the held instruction even if decode is
        // accepting it in the same cycle.
        if (redirect_valid) begin
          instr_valid_n = 1'b0;
          instr_n       = NOP_INSTR;
          pc_n          = redirect_target;
          state_n       = REQ;
        end else if (instr_ready) begin
          instr_valid_n = 1'b0;
          instr_n       = NOP_INSTR;
          pc_n          = pc + 32'd4;
          state_n       = REQ;
        end
      end

      default: begin
        state_n = REQ;
      end
    endcase
  end

endmodule
